// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - shared format codes and RISC-V opcode constants for imm_gen_pipe
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6,
        FMT_NONE = 3'd7
    } fmt_t;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// rtl/imm_gen_pipe_decode.sv - combinational format classifier and immediate builder (IMM_GEN_ZICSR_EN adds fmt Z)
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output fmt_t            fmt,
    output logic            illegal
);

    // Fill with the sign bit first, then overwrite the low bits per format.
    always_comb begin
        imm     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b1;
        case (inst[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM: begin
                fmt       = FMT_I;
                illegal   = 1'b0;
                imm       = {XLEN{inst[31]}};
                imm[11:0] = inst[31:20];
            end
            OPC_SYSTEM: begin
                illegal = 1'b0;
`ifdef IMM_GEN_ZICSR_EN
                if (inst[14]) begin
                    fmt      = FMT_Z;
                    imm[4:0] = inst[19:15];
                end else begin
                    fmt       = FMT_I;
                    imm       = {XLEN{inst[31]}};
                    imm[11:0] = inst[31:20];
                end
`else
                fmt       = FMT_I;
                imm       = {XLEN{inst[31]}};
                imm[11:0] = inst[31:20];
`endif
            end
            OPC_STORE: begin
                fmt       = FMT_S;
                illegal   = 1'b0;
                imm       = {XLEN{inst[31]}};
                imm[11:0] = {inst[31:25], inst[11:7]};
            end
            OPC_BRANCH: begin
                fmt       = FMT_B;
                illegal   = 1'b0;
                imm       = {XLEN{inst[31]}};
                imm[12:0] = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt       = FMT_U;
                illegal   = 1'b0;
                imm       = {XLEN{inst[31]}};
                imm[31:0] = {inst[31:12], 12'b0};
            end
            OPC_JAL: begin
                fmt       = FMT_J;
                illegal   = 1'b0;
                imm       = {XLEN{inst[31]}};
                imm[20:0] = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            OPC_OP: begin
                fmt     = FMT_R;
                illegal = 1'b0;
            end
            OPC_OP_IMM_32: begin
                if (XLEN == 64) begin
                    fmt       = FMT_I;
                    illegal   = 1'b0;
                    imm       = {XLEN{inst[31]}};
                    imm[11:0] = inst[31:20];
                end
            end
            OPC_OP_32: begin
                if (XLEN == 64) begin
                    fmt     = FMT_R;
                    illegal = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined immediate generator with 2-entry skid buffer (IMM_GEN_ZICSR_EN enables fmt Z)
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic [XLEN-1:0]  out_imm,
    output fmt_t             out_fmt,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    logic [XLEN-1:0] dec_imm;
    fmt_t            dec_fmt;
    logic            dec_illegal;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .inst    (in_inst),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    logic            skid_valid;
    logic [31:0]     skid_inst;
    logic [XLEN-1:0] skid_imm;
    fmt_t            skid_fmt;
    logic            skid_illegal;

    logic accept;
    logic main_free;

    assign in_ready  = !skid_valid;
    assign accept    = in_valid && in_ready && !flush;
    assign main_free = !out_valid || out_ready;

    // The main entry doubles as the registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_inst     <= '0;
            out_imm      <= '0;
            out_fmt      <= FMT_R;
            out_illegal  <= 1'b0;
            skid_valid   <= 1'b0;
            skid_inst    <= '0;
            skid_imm     <= '0;
            skid_fmt     <= FMT_R;
            skid_illegal <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            if (skid_valid) begin
                out_valid   <= 1'b1;
                out_inst    <= skid_inst;
                out_imm     <= skid_imm;
                out_fmt     <= skid_fmt;
                out_illegal <= skid_illegal;
                skid_valid  <= accept;
                if (accept) begin
                    skid_inst    <= in_inst;
                    skid_imm     <= dec_imm;
                    skid_fmt     <= dec_fmt;
                    skid_illegal <= dec_illegal;
                end
            end else begin
                out_valid <= accept;
                if (accept) begin
                    out_inst    <= in_inst;
                    out_imm     <= dec_imm;
                    out_fmt     <= dec_fmt;
                    out_illegal <= dec_illegal;
                end
            end
        end else if (accept) begin
            skid_valid   <= 1'b1;
            skid_inst    <= in_inst;
            skid_imm     <= dec_imm;
            skid_fmt     <= dec_fmt;
            skid_illegal <= dec_illegal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (accept && dec_illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
            illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined immediate generator for the decode stage. Accepts one 32-bit instruction per cycle over a valid/ready handshake. Classifies its RISC-V format, produces the XLEN-wide immediate for every base format (I/S/B/U/J), and flags illegal encodings. A 2-entry skid buffer decouples fetch from execute backpressure. A saturating counter records illegal instructions for debug.

## Interface
- `XLEN`, 32: immediate/output width; legal values 32 or 64.
- `CNT_W`, 16: width of the illegal-instruction counter.
- `clk` input 1: clock; rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous pipeline flush.
- `in_valid` input 1: `in_inst` is valid.
- `in_ready` output 1: block can accept this cycle.
- `in_inst` input 32: instruction word.
- `out_valid` output 1: output beat valid.
- `out_ready` input 1: consumer accepts.
- `out_inst` output 32: instruction, passed through.
- `out_imm` output XLEN: generated immediate.
- `out_fmt` output 3: format code (`fmt_t`).
- `out_illegal` output 1: unrecognised encoding.
- `illegal_cnt` output CNT_W: saturating count of accepted illegal beats.

## Operation
- **Decode by `inst[6:0]`**:
  - LOAD 0000011, OP-IMM 0010011, JALR 1100111, MISC-MEM 0001111, SYSTEM 1110011 → I: sext(inst[31:20]).
  - STORE 0100011 → S: sext({inst[31:25],inst[11:7]}).
  - BRANCH 1100011 → B: sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - LUI 0110111, AUIPC 0010111 → U: sext({inst[31:12],12'b0}).
  - JAL 1101111 → J: sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - OP 0110011 → R: imm 0.
  - XLEN=64 only: OP-IMM-32 0011011 → I; OP-32 0111011 → R.
- **Illegal**: any other opcode, or inst[1:0]≠2'b11 → fmt NONE, imm 0, out_illegal=1.
- `sext` sign-extends to XLEN from the immediate's top bit.
- **Skid buffer** has two entries, main and skid:
  - Accept when in_valid & in_ready.
  - A beat lands in main if main is empty or being drained, else in skid.
  - in_ready = !skid_full.
  - When main drains, skid moves into main the same edge.
- **Counter**: illegal_cnt increments on each accepted illegal beat and saturates at 2^CNT_W−1. It is cleared only by reset, not by flush.
- **Flush**: clears both entries on the next edge. A beat presented in the same cycle is dropped and not counted. out_valid=0 and in_ready=1 the following cycle.

## Timing
- **Reset**: out_valid=0, in_ready=1, out_inst=0, out_imm=0, out_fmt=FMT_R (0), out_illegal=0, illegal_cnt=0; both entries empty.
- **Latency**: beat accepted at edge N → out_valid at N+1. Outputs are registered and carry no combinational path from in_*.
- **Throughput**: one beat per cycle while out_ready=1.
- **Backpressure**:
  - out_valid holds and out_* are stable until out_ready.
  - At most one further beat is absorbed into skid; in_ready falls the cycle after skid fills.
- **Simultaneous accept and drain with skid full**: skid→main, and the new beat→skid.
- **Asynchronous reset mid-stream**: all state clears immediately.

## Configuration
- `IMM_GEN_ZICSR_EN` defined: SYSTEM with funct3[2]=1 (CSRRWI/CSRRSI/CSRRCI) → fmt Z, imm = zero-extended inst[19:15].
- Macro undefined: all SYSTEM encodings → I, and fmt Z is never produced.

## Structure
- Shared package `imm_gen_pkg`:
  - `fmt_t`: R=0, I=1, S=2, B=3, U=4, J=5, Z=6, NONE=7.
  - Opcode constants `OPC_*`.
- Sub-module `imm_decode`: purely combinational classifier and immediate builder, parameterised by XLEN, instantiated once ahead of the skid buffer.

## Test plan
- Reset release, XLEN=32:
  - 0xFFF00093 → imm 0xFFFFFFFF, fmt I.
  - 0xFE112E23 → 0xFFFFFFFC, S.
  - 0xFE000CE3 → 0xFFFFFFF8, B.
  - All beats appear one cycle after acceptance.
- U and J formats: 0x123450B7 → 0x12345000, U; 0x0010006F → 0x00000800, J.
- 0x300FD073 → with macro: imm 0x0000001F, fmt Z; without: imm 0x00000300, fmt I.
- Illegal input: 0x00000000 three times → out_illegal=1, fmt NONE each beat, illegal_cnt=3.
- Saturation with CNT_W=2: five illegal beats → illegal_cnt holds 3.
- Stall and flush:
  - out_ready=0 with a stream of 3 beats → in_ready low after 2 accepted; release drains them in order with none lost.
  - flush while full → out_valid=0 next cycle, in_ready=1.
- XLEN=64: 0xFFF0009B (addiw) → imm 0xFFFFFFFFFFFFFFFF, fmt I; same word at XLEN=32 → illegal.
